mole_game_ctrl: RTL

//  Game sequencer for the 9-hole whack-a-mole board. It picks a pseudo-random hole,

---
 rtl/mole_game_ctrl_if.sv | 21 ++
 rtl/mole_game_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl_if.sv
// Pin-side bundle of the whack-a-mole sequencer: raw start/button inputs,
// LED drive, BCD score digits and game status.
interface mole_game_ctrl_if;
  logic       start;
  logic [8:0] btn;
  logic [8:0] mole;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic       hit;
  logic       game_over;

  modport master (
    output start, btn,
    input  mole, score_ones, score_tens, hit, game_over
  );

  modport slave (
    input  start, btn,
    output mole, score_ones, score_tens, hit, game_over
  );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole sequencer: lights a pseudo-random hole for a timed window,
// scores matching button edges in BCD and stops after ROUNDS moles.
module mole_game_ctrl #(
  parameter int unsigned MOLE_TICKS = 100000000,
  parameter int unsigned GAP_TICKS  = 25000000,
  parameter int unsigned ROUNDS     = 30,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic             cin,
  input logic             rst,
  mole_game_ctrl_if.slave bus
);

  // state | meaning
  // IDLE  | after reset, LEDs dark, waiting for a start edge
  // PICK  | one cycle: choose the next hole and light it
  // SHOW  | mole lit, waiting for its button edge or the timeout
  // GAP   | LEDs dark between moles, decides next mole or game end
  // DONE  | game over, score held until a start edge
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_SHOW,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [31:0] MOLE_LAST = 32'(MOLE_TICKS - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);
  localparam logic [7:0]  ROUND_MAX = 8'(ROUNDS);

  state_t      state_q, state_d;
  logic [2:0]  start_sync_q, start_sync_d;
  logic [8:0]  btn_s1_q, btn_s1_d;
  logic [8:0]  btn_s2_q, btn_s2_d;
  logic [8:0]  btn_s3_q, btn_s3_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [3:0]  prev_idx_q, prev_idx_d;
  logic [3:0]  cur_idx_q, cur_idx_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  round_q, round_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [8:0]  mole_q, mole_d;
  logic        hit_q, hit_d;
  logic        game_over_q, game_over_d;

  logic        start_edge;
  logic [8:0]  btn_edge;
  logic [3:0]  cand;
  logic [3:0]  idx_sel;

  assign start_edge = start_sync_q[1] & ~start_sync_q[2];
  assign btn_edge   = btn_s2_q & ~btn_s3_q;
  assign cand       = 4'(lfsr_q % 8'd9);
  // Bump a repeat of the previous hole to the next one so moles never repeat.
  assign idx_sel    = (cand == prev_idx_q) ? ((cand == 4'd8) ? 4'd0 : cand + 4'd1) : cand;

  always_comb begin
    start_sync_d = {start_sync_q[1:0], bus.start};
    btn_s1_d     = bus.btn;
    btn_s2_d     = btn_s1_q;
    btn_s3_d     = btn_s2_q;
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_comb begin
    state_d     = state_q;
    prev_idx_d  = prev_idx_q;
    cur_idx_d   = cur_idx_q;
    timer_d     = timer_q;
    round_d     = round_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    mole_d      = mole_q;
    hit_d       = 1'b0;
    game_over_d = game_over_q;

    case (state_q)
      ST_IDLE: begin
        mole_d = '0;
        if (start_edge) begin
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          round_d = 8'd0;
          state_d = ST_PICK;
        end
      end
      ST_PICK: begin
        cur_idx_d  = idx_sel;
        prev_idx_d = idx_sel;
        mole_d     = 9'd1 << idx_sel;
        timer_d    = '0;
        state_d    = ST_SHOW;
      end
      ST_SHOW: begin
        timer_d = timer_q + 32'd1;
        // The hit is tested first so a press landing on the timeout cycle still scores.
        if (btn_edge[cur_idx_q]) begin
          hit_d   = 1'b1;
          mole_d  = '0;
          timer_d = '0;
          round_d = round_q + 8'd1;
          state_d = ST_GAP;
          if (!(ones_q == 4'd9 && tens_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end else if (timer_q == MOLE_LAST) begin
          mole_d  = '0;
          timer_d = '0;
          round_d = round_q + 8'd1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        mole_d  = '0;
        timer_d = timer_q + 32'd1;
        if (timer_q == GAP_LAST) begin
          if (round_q == ROUND_MAX) begin
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_PICK;
          end
        end
      end
      ST_DONE: begin
        mole_d      = '0;
        game_over_d = 1'b1;
        if (start_edge) begin
          ones_d      = 4'd0;
          tens_d      = 4'd0;
          round_d     = 8'd0;
          game_over_d = 1'b0;
          state_d     = ST_PICK;
        end
      end
      default: begin
        mole_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_sync_q <= '0;
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      btn_s3_q     <= '0;
      lfsr_q       <= LFSR_SEED;
      prev_idx_q   <= '0;
      cur_idx_q    <= '0;
      timer_q      <= '0;
      round_q      <= '0;
      ones_q       <= '0;
      tens_q       <= '0;
      mole_q       <= '0;
      hit_q        <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_sync_q <= start_sync_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      btn_s3_q     <= btn_s3_d;
      lfsr_q       <= lfsr_d;
      prev_idx_q   <= prev_idx_d;
      cur_idx_q    <= cur_idx_d;
      timer_q      <= timer_d;
      round_q      <= round_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      mole_q       <= mole_d;
      hit_q        <= hit_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.mole       = mole_q;
  assign bus.score_ones = ones_q;
  assign bus.score_tens = tens_q;
  assign bus.hit        = hit_q;
  assign bus.game_over  = game_over_q;

endmodule
